// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package intr_pkg;
    localparam int NUM_IRQ = 8;
    localparam int IRQ_W   = 3;
    localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

    // Priority rank carries one extra bit so "nothing in service" (8) ranks
    // below every real source and a plain less-than decides preemption.
    localparam logic [IRQ_W:0] PRIO_NONE = 4'd8;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;
    typedef logic [IRQ_W-1:0]   irq_idx_t;
endpackage

// File: rtl/intr_if.sv
// CPU-side bus of the interrupt controller: request lines, mask write, ack/eoi, status.
// Latency: n/a (wires only).
// Backpressure: none; iack/eoi are single-cycle pulses.
// Ports: master = CPU/stimulus side, slave = controller side.
interface intr_if;
    import intr_pkg::*;

    irq_vec_t req;
    logic     mask_we;
    irq_vec_t mask_wdata;
    logic     iack;
    logic     eoi;
    logic     interrupt;
    irq_idx_t irq;
    irq_vec_t pending;
    irq_vec_t in_service;
    irq_vec_t mask;

    modport master (
        output req, mask_we, mask_wdata, iack, eoi,
        input  interrupt, irq, pending, in_service, mask
    );

    modport slave (
        input  req, mask_we, mask_wdata, iack, eoi,
        output interrupt, irq, pending, in_service, mask
    );
endinterface

// File: rtl/prio_enc8.sv
// Fixed-priority encoder: index of the lowest set bit of an 8-bit vector, plus valid.
// Latency: combinational.
// Backpressure: none.
// Ports: i_vec in, o_idx lowest set index (0 when empty), o_vld any bit set.
module prio_enc8
    import intr_pkg::*;
(
    input  logic [7:0] i_vec,
    output irq_idx_t   o_idx,
    output logic       o_vld
);
    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = irq_idx_t'(i);
                o_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered, fixed-priority, nesting interrupt controller (index 0 highest).
// Latency: req rise sampled at edge k -> pending after k, interrupt/irq after k+1.
// Backpressure: interrupt holds until iack or until it loses eligibility; iack ignored while idle.
// Ports: clock, reset (sync, active high), bus (intr_if.slave: req/mask/iack/eoi in, status out).
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int                 NUM_IRQ  = intr_pkg::NUM_IRQ,
    parameter logic [NUM_IRQ-1:0] MASK_RST = intr_pkg::MASK_RST
)(
    input  logic  clock,
    input  logic  reset,
    intr_if.slave bus
);
    logic [NUM_IRQ-1:0] r_req_d;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [NUM_IRQ-1:0] r_mask;
    logic               r_rst_q;
    logic               r_interrupt;
    irq_idx_t           r_irq;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_cand;
    logic [NUM_IRQ-1:0] w_ack_set;
    logic [NUM_IRQ-1:0] w_eoi_clr;
    irq_idx_t           w_hp_idx;
    irq_idx_t           w_cur_idx;
    logic               w_hp_vld;
    logic               w_cur_vld;
    logic [IRQ_W:0]     w_cur_rank;
    logic               w_fire;
    logic               w_ack;

    // The history register is cleared by reset, so on the first edge after
    // reset a line that was held high would look like a fresh rise. r_rst_q
    // suppresses edges for that one cycle; the line must fall and rise again.
    assign w_edge = bus.req & ~r_req_d & {NUM_IRQ{~r_rst_q}};
    assign w_cand = r_pending & ~r_mask;

    prio_enc8 u_enc_cand (
        .i_vec (w_cand),
        .o_idx (w_hp_idx),
        .o_vld (w_hp_vld)
    );

    prio_enc8 u_enc_isr (
        .i_vec (r_in_service),
        .o_idx (w_cur_idx),
        .o_vld (w_cur_vld)
    );

    // Strictly higher priority than the current service level may preempt.
    assign w_cur_rank = w_cur_vld ? {1'b0, w_cur_idx} : PRIO_NONE;
    assign w_fire     = w_hp_vld && ({1'b0, w_hp_idx} < w_cur_rank);

    assign w_ack     = bus.iack & r_interrupt;
    assign w_ack_set = w_ack ? (NUM_IRQ'(1) << r_irq) : '0;
    assign w_eoi_clr = (bus.eoi && w_cur_vld) ? (NUM_IRQ'(1) << w_cur_idx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_d      <= '0;
            r_rst_q      <= 1'b1;
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= MASK_RST;
            r_interrupt  <= 1'b0;
            r_irq        <= '0;
        end else begin
            r_rst_q      <= 1'b0;
            r_req_d      <= bus.req;
            // A new edge on the source being acknowledged re-arms it.
            r_pending    <= (r_pending & ~w_ack_set) | w_edge;
            // eoi retires the old top level before the acknowledged bit lands.
            r_in_service <= (r_in_service & ~w_eoi_clr) | w_ack_set;
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end
            if (w_ack) begin
                r_interrupt <= 1'b0;
            end else begin
                r_interrupt <= w_fire;
                if (w_fire) begin
                    r_irq <= w_hp_idx;
                end
            end
        end
    end

    assign bus.interrupt  = r_interrupt;
    assign bus.irq        = r_irq;
    assign bus.pending    = r_pending;
    assign bus.in_service = r_in_service;
    assign bus.mask       = r_mask;
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: vector table plus hand-written reset sequence.
// Latency: each step drives inputs, takes one clock edge, checks outputs 1 ns later.
// Backpressure: n/a.
module tb_intr_ctrl;
    import intr_pkg::*;

    typedef struct packed {
        logic [7:0] req;
        logic       mwe;
        logic [7:0] mwd;
        logic       iack;
        logic       eoi;
        logic       intr;
        logic [2:0] irq;
        logic [7:0] pend;
        logic [7:0] insv;
        logic [7:0] mask;
    } row_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    intr_if bus ();

    intr_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    row_t sb[$];
    row_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    function automatic row_t R(input logic [7:0] req, input logic mwe, input logic [7:0] mwd,
                               input logic iack, input logic eoi, input logic intr,
                               input logic [2:0] irq, input logic [7:0] pend,
                               input logic [7:0] insv, input logic [7:0] mask);
        row_t r;
        r.req = req; r.mwe = mwe; r.mwd = mwd; r.iack = iack; r.eoi = eoi;
        r.intr = intr; r.irq = irq; r.pend = pend; r.insv = insv; r.mask = mask;
        return r;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, clock, then check.
    task automatic step(input row_t r, input logic rst);
        row_t e;
        reset          = rst;
        bus.req        = r.req;
        bus.mask_we    = r.mwe;
        bus.mask_wdata = r.mwd;
        bus.iack       = r.iack;
        bus.eoi        = r.eoi;
        sb.push_back(r);
        @(posedge clock);
        #1;
        step_no++;
        e = sb.pop_front();
        cmp("interrupt",  step_no, 8'(bus.interrupt), 8'(e.intr));
        cmp("irq",        step_no, 8'(bus.irq),       8'(e.irq));
        cmp("pending",    step_no, bus.pending,       e.pend);
        cmp("in_service", step_no, bus.in_service,    e.insv);
        cmp("mask",       step_no, bus.mask,          e.mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.req = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.iack = 1'b0; bus.eoi = 1'b0;

        // Reset state and first idle cycle after reset.
        step(R(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'hFF), 1'b1);
        step(R(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'hFF), 1'b1);
        step(R(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'hFF), 1'b0);

        //          req  mwe mwd iak eoi  int irq  pend  insv  mask
        // single request on line 2
        tbl.push_back(R(8'h00,1,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'h00));
        tbl.push_back(R(8'h04,0,8'h00,0,0, 0,3'd0,8'h04,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd2,8'h04,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd2,8'h00,8'h04,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 0,3'd2,8'h00,8'h04,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd2,8'h00,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd2,8'h00,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd2,8'h00,8'h00,8'h00));
        // lines 5 and 1 together: 1 wins, 5 waits for eoi
        tbl.push_back(R(8'h22,0,8'h00,0,0, 0,3'd2,8'h22,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd1,8'h22,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd1,8'h20,8'h02,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 0,3'd1,8'h20,8'h02,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 0,3'd1,8'h20,8'h02,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd1,8'h20,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd5,8'h20,8'h00,8'h00));
        // nesting: 3 preempts 5, then 7 is held off by both
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd5,8'h00,8'h20,8'h00));
        tbl.push_back(R(8'h08,0,8'h00,0,0, 0,3'd5,8'h08,8'h20,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd3,8'h08,8'h20,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd3,8'h00,8'h28,8'h00));
        tbl.push_back(R(8'h80,0,8'h00,0,0, 0,3'd3,8'h80,8'h28,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 0,3'd3,8'h80,8'h28,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd3,8'h80,8'h20,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd3,8'h80,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd7,8'h80,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd7,8'h00,8'h80,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd7,8'h00,8'h00,8'h00));
        // masking keeps pending; unmask raises interrupt one edge later
        tbl.push_back(R(8'h00,1,8'hFF,0,0, 0,3'd7,8'h00,8'h00,8'hFF));
        tbl.push_back(R(8'h10,0,8'h00,0,0, 0,3'd7,8'h10,8'h00,8'hFF));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 0,3'd7,8'h10,8'h00,8'hFF));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd7,8'h10,8'h00,8'hFF));
        tbl.push_back(R(8'h00,1,8'hEF,0,0, 0,3'd7,8'h10,8'h00,8'hEF));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd4,8'h10,8'h00,8'hEF));
        tbl.push_back(R(8'h00,1,8'hFF,0,0, 1,3'd4,8'h10,8'h00,8'hFF));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 0,3'd4,8'h10,8'h00,8'hFF));
        tbl.push_back(R(8'h00,1,8'h00,0,0, 0,3'd4,8'h10,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd4,8'h10,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd4,8'h00,8'h10,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd4,8'h00,8'h00,8'h00));
        // new edge on line 0 coincides with its iack; equal level blocked
        tbl.push_back(R(8'h01,0,8'h00,0,0, 0,3'd4,8'h01,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd0,8'h01,8'h00,8'h00));
        tbl.push_back(R(8'h01,0,8'h00,1,0, 0,3'd0,8'h01,8'h01,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 0,3'd0,8'h01,8'h01,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd0,8'h01,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd0,8'h01,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd0,8'h00,8'h01,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd0,8'h00,8'h00,8'h00));
        // iack and eoi on one edge: line 1 retired, line 0 entered
        tbl.push_back(R(8'h02,0,8'h00,0,0, 0,3'd0,8'h02,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd1,8'h02,8'h00,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,0, 0,3'd1,8'h00,8'h02,8'h00));
        tbl.push_back(R(8'h01,0,8'h00,0,0, 0,3'd1,8'h01,8'h02,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,0, 1,3'd0,8'h01,8'h02,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,1,1, 0,3'd0,8'h00,8'h01,8'h00));
        tbl.push_back(R(8'h00,0,8'h00,0,1, 0,3'd0,8'h00,8'h00,8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b0);
        end

        // Reset mid-service with line 6 held high across reset.
        step(R(8'h02,0,8'h00,0,0, 0,3'd0,8'h02,8'h00,8'h00), 1'b0);
        step(R(8'h00,0,8'h00,0,0, 1,3'd1,8'h02,8'h00,8'h00), 1'b0);
        step(R(8'h00,0,8'h00,1,0, 0,3'd1,8'h00,8'h02,8'h00), 1'b0);
        step(R(8'h40,0,8'h00,0,0, 0,3'd1,8'h40,8'h02,8'h00), 1'b0);
        step(R(8'h40,0,8'h00,0,0, 0,3'd1,8'h40,8'h02,8'h00), 1'b0);
        // reset overrides a simultaneous iack and mask write
        step(R(8'h40,1,8'h00,1,0, 0,3'd0,8'h00,8'h00,8'hFF), 1'b1);
        step(R(8'h40,1,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'h00), 1'b0);
        step(R(8'h40,0,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'h00), 1'b0);
        step(R(8'h40,0,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'h00), 1'b0);
        // falling then rising again does re-request
        step(R(8'h00,0,8'h00,0,0, 0,3'd0,8'h00,8'h00,8'h00), 1'b0);
        step(R(8'h40,0,8'h00,0,0, 0,3'd0,8'h40,8'h00,8'h00), 1'b0);
        step(R(8'h00,0,8'h00,0,0, 1,3'd6,8'h40,8'h00,8'h00), 1'b0);
        step(R(8'h00,0,8'h00,1,0, 0,3'd6,8'h00,8'h40,8'h00), 1'b0);
        step(R(8'h00,0,8'h00,0,1, 0,3'd6,8'h00,8'h00,8'h00), 1'b0);

        cmp("scoreboard_empty", step_no, 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
